// File: rtl/gray_pkg.sv
// Shared width constant, operation codes and Gray/binary conversion helpers.
package gray_pkg;

  localparam int unsigned GRAY_W     = 8;
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_EMIT,
    OP_IDLE
  } op_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended narrow codes convert unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and output-beat bundle of the Gray sequence source.
interface gray_counter_if
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             tc;

  modport master (
    output en, up, load, load_val, out_ready,
    input  out_valid, bin, gray, tc
  );

  modport slave (
    input  en, up, load, load_val, out_ready,
    output out_valid, bin, gray, tc
  );

endinterface

// File: rtl/gray_counter.sv
// Registered binary/Gray sequence source with a valid/ready output beat.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  bus
);

  logic             accept;
  op_e              op;
  logic [WIDTH-1:0] n_q, n_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  always_comb begin
    accept = !valid_q || bus.out_ready;
    op     = OP_HOLD;
    if (bus.load) begin
      op = OP_LOAD;
    end else if (accept) begin
      op = bus.en ? OP_EMIT : OP_IDLE;
    end
  end

  always_comb begin
    n_d     = n_q;
    valid_d = valid_q;
    bin_d   = bin_q;
    gray_d  = gray_q;
    tc_d    = tc_q;
    unique case (op)
      OP_LOAD: begin
        n_d = bus.load_val;
        // A stalled beat survives a load; only an accepted one is retired.
        if (accept) valid_d = 1'b0;
      end
      OP_EMIT: begin
        valid_d = 1'b1;
        bin_d   = n_q;
        gray_d  = WIDTH'(bin2gray(GRAY_MAX_W'(n_q)));
        tc_d    = (bus.up && n_q == '1) || (!bus.up && n_q == '0);
        n_d     = bus.up ? n_q + WIDTH'(1) : n_q - WIDTH'(1);
      end
      OP_IDLE: valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q     <= '0;
      valid_q <= 1'b0;
      bin_q   <= '0;
      gray_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      n_q     <= n_d;
      valid_q <= valid_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.bin       = bin_q;
  assign bus.gray      = gray_q;
  assign bus.tc        = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed plan plus randomized traffic against an arithmetic model of the counter.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int unsigned W    = 8;
  localparam int          MASK = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(W)) bus ();
  gray_counter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  int m_n, m_valid, m_bin, m_gray, m_tc;
  int prev_gray;
  bit streaming = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input bit rdy);
    bit acc;
    bit emitted;
    rst_n         = r;
    bus.en        = e;
    bus.up        = u;
    bus.load      = l;
    bus.load_val  = lv[W-1:0];
    bus.out_ready = rdy;
    acc     = (m_valid == 0) || rdy;
    emitted = 1'b0;
    @(posedge clk);
    if (!r) begin
      m_n = 0; m_valid = 0; m_bin = 0; m_gray = 0; m_tc = 0;
      streaming = 1'b0;
    end else if (l) begin
      m_n = lv & MASK;
      if (acc) m_valid = 0;
      streaming = 1'b0;
    end else if (acc) begin
      if (e) begin
        m_bin   = m_n;
        m_gray  = m_n ^ (m_n >> 1);
        m_tc    = u ? int'(m_n == MASK) : int'(m_n == 0);
        m_valid = 1;
        m_n     = u ? ((m_n + 1) & MASK) : ((m_n + MASK) & MASK);
        emitted = 1'b1;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("bin",       32'(bus.bin),       32'(m_bin));
    check("gray",      32'(bus.gray),      32'(m_gray));
    check("tc",        32'(bus.tc),        32'(m_tc));
    if (emitted) begin
      check("gray2bin", gray2bin(32'(bus.gray)), 32'(m_bin));
      if (streaming) check("gray_onebit", 32'($countones(32'(bus.gray) ^ 32'(prev_gray))), 32'd1);
      prev_gray = m_gray;
      streaming = 1'b1;
    end
  endtask

  initial begin
    int eb[3];
    int eg[3];
    int et[3];
    m_n = 0; m_valid = 0; m_bin = 0; m_gray = 0; m_tc = 0; prev_gray = 0;

    // Reset with en low
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);

    // Stream 0..3 upward
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 0, 1);
      check("plan_up_bin", 32'(bus.bin), 32'(i));
    end
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    check("plan_bin5",  32'(bus.bin),  32'h05);
    check("plan_gray5", 32'(bus.gray), 32'h07);

    // Stall three cycles, then release
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 0);
      check("stall_bin",  32'(bus.bin),  32'h05);
      check("stall_gray", 32'(bus.gray), 32'h07);
    end
    step(1, 1, 1, 0, 0, 1);
    check("resume_bin",  32'(bus.bin),  32'h06);
    check("resume_gray", 32'(bus.gray), 32'h05);

    // Load 0xFE and count up across the wrap
    step(1, 1, 1, 1, 'hFE, 1);
    check("load_valid", 32'(bus.out_valid), 32'd0);
    eb = '{'hFE, 'hFF, 'h00}; eg = '{'h81, 'h80, 'h00}; et = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 1);
      check("wrap_up_bin",  32'(bus.bin),  32'(eb[i]));
      check("wrap_up_gray", 32'(bus.gray), 32'(eg[i]));
      check("wrap_up_tc",   32'(bus.tc),   32'(et[i]));
    end

    // Load 0x01 and count down across the wrap
    step(1, 0, 0, 1, 'h01, 1);
    eb = '{'h01, 'h00, 'hFF}; eg = '{'h01, 'h00, 'h80}; et = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 1);
      check("wrap_dn_bin",  32'(bus.bin),  32'(eb[i]));
      check("wrap_dn_gray", 32'(bus.gray), 32'(eg[i]));
      check("wrap_dn_tc",   32'(bus.tc),   32'(et[i]));
    end

    // Reset while a beat is stalled
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check("rst_stall_valid", 32'(bus.out_valid), 32'd0);
    check("rst_stall_bin",   32'(bus.bin),       32'd0);
    step(1, 1, 1, 0, 0, 1);
    check("post_rst_bin",   32'(bus.bin),       32'd0);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31) != 0), ($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(7) == 0), int'($urandom_range(255)), ($urandom_range(3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Synchronous Gray-code sequence source that feeds the combinational binary-to-Gray stage's consumers directly with pre-registered values. It maintains an internal binary count and emits one beat per accepted cycle: binary value, matching Gray code and a wrap flag. Output uses a valid/ready handshake so downstream logic can stall the sequence without losing or skipping codes.

## Interface
- WIDTH, 8, count and code width in bits (minimum 2)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk
- en  input  1  request to emit the next value and advance the count
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  overwrite internal next-value with load_val
- load_val  input  WIDTH  binary load value
- out_ready  input  1  downstream accepts the current beat
- out_valid  output  1  beat on bin/gray/tc is valid
- bin  output  WIDTH  binary value of current beat
- gray  output  WIDTH  Gray code of bin: gray = bin ^ (bin >> 1)
- tc  output  1  beat is the last before wrap in current direction

## Operation
- State: next-value register N (WIDTH bits), output registers out_valid, bin, gray, tc.
- accept = !out_valid || out_ready, evaluated every cycle.
- Per rising edge, priority order:
  - rst_n=0: N=0, out_valid=0, bin=0, gray=0, tc=0. Overrides all else, including a stalled beat.
  - load=1: N=load_val. If accept: out_valid=0. Else output registers held. No beat emitted; en ignored this cycle.
  - en=1 and accept: bin=N, gray=bin2gray(N), tc=(up && N==all-ones) || (!up && N==0), out_valid=1; N=N+1 if up, N-1 if !up, modulo 2^WIDTH.
  - en=0 and accept: out_valid=0; bin/gray/tc hold last values; N unchanged.
  - !accept (out_valid=1, out_ready=0): all outputs and N held, regardless of en/up.
- Wrap: up from all-ones gives 0; down from 0 gives all-ones. tc set only on the beat carrying the wrap-point value.
- Direction change: takes effect on the next accepted step; the value in N is emitted first, unchanged.
- Consecutive beats in steady stream differ in exactly one gray bit, including across wrap.

## Timing
- All outputs registered; no combinational input-to-output path.
- Latency: en sampled high with accept at edge t → beat visible after edge t, value = N at edge t.
- Throughput: one beat per cycle with en=1, out_ready=1.
- Handshake: while out_valid=1 and out_ready=0, bin/gray/tc stable; beat consumed on edge where out_valid && out_ready.
- Load at edge t, en at edge t+1 → beat load_val visible after t+1.
- Reset beat after deassertion: first accepted en emits 0.

## Structure
- Package gray_pkg: default width constant GRAY_W=8; functions bin2gray and gray2bin (latter for bench checking).
- No sub-module; conversion via gray_pkg::bin2gray inside the output register process.

## Test plan
- Reset with en=0 for 3 cycles → out_valid=0, bin=0x00, gray=0x00, tc=0 throughout.
- After reset, en=1, up=1, out_ready=1 for 4 cycles → beats bin 0,1,2,3 / gray 0x00,0x01,0x03,0x02 on consecutive cycles, tc=0.
- Stream reaches bin=0x05 (gray 0x07), out_ready=0 for 3 cycles with en=1 → outputs frozen at 0x05/0x07, out_valid=1; out_ready=1 → next beat 0x06/gray 0x05, no value skipped.
- load=1, load_val=0xFE, then en=1, up=1 → beats 0xFE/0x81 tc=0, 0xFF/0x80 tc=1, 0x00/0x00 tc=0.
- load_val=0x01, en=1, up=0 → beats 0x01/0x01 tc=0, 0x00/0x00 tc=1, 0xFF/0x80 tc=0.
- Mid-stream with out_valid=1, out_ready=0, drive rst_n=0 one cycle → next edge out_valid=0, bin=gray=0, tc=0; after release, en=1 → first beat 0x00.
